program_state_stack: RTL and testbench

Parametrised successor to the single program-state register. Holds the current program state plus a LIFO of saved states for nested trap entry and return. Supports in-place alteration, push (trap entry: save current, load new) and pop (trap return: restore most recent saved).
Sits between the trap/CSR control logic and every consumer of the current program state (fetch, privilege checks, CSR reads).

---
 rtl/ps_pkg.sv | 33 +++
 rtl/ps_lifo.sv | 54 +++++
 rtl/program_state_stack.sv | 89 ++++++++
 tb/tb_program_state_stack.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ps_pkg.sv
// Shared program-state types: state layout, command encoding and decode.
package ps_pkg;

  // Current program state: privilege level, interrupt enables and mode bits.
  typedef struct packed {
    logic [1:0] priv;
    logic       ie;
    logic       pie;
    logic [3:0] mode;
  } program_state_t;

  localparam int PS_W               = $bits(program_state_t);
  localparam int PS_STACK_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    PS_CMD_NONE,
    PS_CMD_ALTER,
    PS_CMD_PUSH,
    PS_CMD_POP
  } ps_cmd_e;

  // Priority encode of the request lines: push beats pop beats alter.
  function automatic ps_cmd_e ps_cmd_decode(input logic alter, input logic push,
                                            input logic pop);
    ps_cmd_e cmd;
    cmd = PS_CMD_NONE;
    if (push)       cmd = PS_CMD_PUSH;
    else if (pop)   cmd = PS_CMD_POP;
    else if (alter) cmd = PS_CMD_ALTER;
    return cmd;
  endfunction

endpackage

// File: rtl/ps_lifo.sv
// Parametrised LIFO storage for saved program states. A push while full and
// a pop while empty are ignored here; error reporting lives in the parent.
module ps_lifo
  import ps_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  program_state_t wdata_i,
  output program_state_t top_o,
  output logic [DW-1:0]  depth_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  program_state_t mem_q [DEPTH];
  logic [DW-1:0]  depth_q, depth_d;
  logic [AW-1:0]  wr_idx, rd_idx;
  logic           do_push, do_pop;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;
  assign wr_idx  = AW'(depth_q);
  assign rd_idx  = AW'(depth_q - DW'(1));
  assign depth_o = depth_q;
  assign top_o   = empty_o ? '0 : mem_q[rd_idx];

  // Next depth: saturating up/down count.
  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
  end

  // Depth pointer register; cleared on reset so all entries become invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) depth_q <= '0;
    else          depth_q <= depth_d;
  end

  // Storage write at the pointer; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && do_push) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/program_state_stack.sv
// Current program state plus a LIFO of saved states for nested traps.
module program_state_stack
  import ps_pkg::*;
#(
  parameter int             DEPTH    = 4,
  parameter program_state_t RESET_PS = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_alter,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  program_state_t               i_ps,
  input  logic                         i_clr_err,
  output program_state_t               o_ps,
  output program_state_t               o_top_ps,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int DW = $clog2(DEPTH + 1);

  program_state_t ps_q, ps_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  ps_cmd_e        cmd;
  logic           lifo_push, lifo_pop;
  logic           full, empty;
  program_state_t top;

  assign cmd       = ps_cmd_decode(i_alter, i_push, i_pop);
  assign lifo_push = (cmd == PS_CMD_PUSH);
  assign lifo_pop  = (cmd == PS_CMD_POP);

  ps_lifo #(.DEPTH(DEPTH), .DW(DW)) u_lifo (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .push_i  (lifo_push),
    .pop_i   (lifo_pop),
    .wdata_i (ps_q),
    .top_o   (top),
    .depth_o (o_depth),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next current state and sticky flags; a new error event beats a clear.
  always_comb begin
    ps_d  = ps_q;
    ovf_d = ovf_q && !i_clr_err;
    unf_d = unf_q && !i_clr_err;
    case (cmd)
      PS_CMD_ALTER: ps_d = i_ps;
      PS_CMD_PUSH: begin
        ps_d = i_ps;
        if (full) ovf_d = 1'b1;
      end
      PS_CMD_POP: begin
        if (empty) unf_d = 1'b1;
        else       ps_d  = top;
      end
      default: ;
    endcase
  end

  // Current-state and flag registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ps_q  <= RESET_PS;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_ps        = ps_q;
  assign o_top_ps    = top;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_program_state_stack.sv
// Directed plus randomized checks of program_state_stack against a queue model.
module tb_program_state_stack;
  import ps_pkg::*;

  localparam int             DEPTH    = 4;
  localparam int             DW       = $clog2(DEPTH + 1);
  localparam program_state_t RESET_PS = '0;

  logic           clk = 1'b0;
  logic           rst_n, alter, push, pop, clr;
  program_state_t ps_in;
  program_state_t o_ps, o_top_ps;
  logic [DW-1:0]  o_depth;
  logic           o_empty, o_full, o_overflow, o_underflow;

  program_state_stack #(.DEPTH(DEPTH), .RESET_PS(RESET_PS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alter     (alter),
    .i_push      (push),
    .i_pop       (pop),
    .i_ps        (ps_in),
    .i_clr_err   (clr),
    .o_ps        (o_ps),
    .o_top_ps    (o_top_ps),
    .o_depth     (o_depth),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Reference model: current state, a queue of saved states and two flags.
  program_state_t m_ps;
  program_state_t m_q[$];
  logic           m_ovf, m_unf;
  int             n_checks = 0;
  int             n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic ov_ev, un_ev;
    ov_ev = 1'b0;
    un_ev = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_ps  = RESET_PS;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_ps);
        else                    ov_ev = 1'b1;
        m_ps = ps_in;
      end else if (pop) begin
        if (m_q.size() > 0) m_ps = m_q.pop_back();
        else                un_ev = 1'b1;
      end else if (alter) begin
        m_ps = ps_in;
      end
      m_ovf = (m_ovf && !clr) || ov_ev;
      m_unf = (m_unf && !clr) || un_ev;
    end
  endtask

  task automatic check_all(input string where);
    program_state_t exp_top;
    exp_top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
    chk({where, ".ps"},    32'(o_ps),        32'(m_ps));
    chk({where, ".top"},   32'(o_top_ps),    32'(exp_top));
    chk({where, ".depth"}, 32'(o_depth),     32'(m_q.size()));
    chk({where, ".empty"}, 32'(o_empty),     32'(m_q.size() == 0));
    chk({where, ".full"},  32'(o_full),      32'(m_q.size() == DEPTH));
    chk({where, ".ovf"},   32'(o_overflow),  32'(m_ovf));
    chk({where, ".unf"},   32'(o_underflow), 32'(m_unf));
  endtask

  // Drive one cycle of inputs, advance model at the edge, check #1 later.
  task automatic step(input string where, input logic r, input logic a,
                      input logic pu, input logic po, input logic c,
                      input program_state_t v);
    rst_n = r; alter = a; push = pu; pop = po; clr = c; ps_in = v;
    @(posedge clk);
    model_update();
    #1;
    check_all(where);
  endtask

  localparam program_state_t A = 8'h11;
  localparam program_state_t B = 8'h2B;
  localparam program_state_t C = 8'hC3;

  initial begin
    rst_n = 1'b0; alter = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; ps_in = '0;
    m_ps = '0; m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    step("reset", 0, 0, 0, 0, 0, '0);
    step("alter_a", 1, 1, 0, 0, 0, A);
    chk("alter_a.lit", 32'(o_ps), 32'(A));
    step("push_b", 1, 0, 1, 0, 0, B);
    step("push_c", 1, 0, 1, 0, 0, C);
    chk("push_c.top_lit", 32'(o_top_ps), 32'(B));
    step("pop1", 1, 0, 0, 1, 0, '0);
    step("pop2", 1, 0, 0, 1, 0, '0);
    chk("pop2.ps_lit", 32'(o_ps), 32'(A));
    // Five pushes from A: fifth overflows
    for (int i = 1; i <= 5; i++) step("push_p", 1, 0, 1, 0, 0, program_state_t'(8'h40 + i));
    chk("p5.ovf_lit", 32'(o_overflow), 32'd1);
    chk("p5.depth_lit", 32'(o_depth), 32'(DEPTH));
    for (int i = 0; i < 4; i++) step("pop_p", 1, 0, 0, 1, 0, '0);
    chk("restore_a", 32'(o_ps), 32'(A));
    // Underflow and clear interplay
    step("clr_ovf", 1, 0, 0, 0, 1, '0);
    step("pop_empty", 1, 0, 0, 1, 0, '0);
    step("clr_with_pop", 1, 0, 0, 1, 1, '0);
    chk("clr_with_pop.lit", 32'(o_underflow), 32'd1);
    step("clr_alone", 1, 0, 0, 0, 1, '0);
    // Priority
    step("all_three", 1, 1, 1, 1, 0, B);
    step("pop_alter", 1, 1, 0, 1, 0, C);
    chk("pop_alter.lit", 32'(o_ps), 32'(A));
    // Reset mid-sequence with push asserted
    for (int i = 0; i < 3; i++) step("fill3", 1, 0, 1, 0, 0, program_state_t'(8'h70 + i));
    step("rst_push", 0, 0, 1, 0, 0, C);
    step("idle", 1, 0, 0, 0, 0, B);
    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int k;
      k = int'($urandom_range(0, 99));
      step("rand", (k != 0), ($urandom_range(0, 3) == 0), (k >= 1 && k < 40),
           (k >= 40 && k < 75), ($urandom_range(0, 9) == 0), program_state_t'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
